vram_wr_arbiter: RTL
====================

# vram_wr_arbiter

Shares the single-port synchronous video RAM between the CPU store path and the VGA scanout reader. CPU stores to VRAM space (the CPU's `wvram` strobe with `m_addr`/`d_t_mem`) are posted into a small write FIFO and never stall the CPU. Queued writes drain into VRAM on cycles when scanout is not reading. Scanout always wins, so display timing is never disturbed. FIFO status is exported for software polling through the I/O space decode.

## Interface

Parameters:
- `AW`, 13: VRAM word-address width.
- `DW`, 32: data width.
- `DEPTH`, 4: write-FIFO entries; power of two, minimum 2.

Ports (clock and reset first):
- `clk`  in  1  system clock; same clock as the CPU.
- `clr`  in  1  synchronous, active-high reset.
- `cpu_we`  in  1  CPU VRAM write strobe (`wvram`); one store per high cycle.
- `cpu_addr`  in  32  CPU byte address (`m_addr`); word index is `cpu_addr[AW+1:2]`.
- `cpu_data`  in  DW  CPU store data (`d_t_mem`).
- `vga_req`  in  1  scanout read request, this cycle.
- `vga_addr`  in  AW  scanout word address.
- `vga_data`  out  DW  scanout read data.
- `vga_valid`  out  1  `vga_data` valid; one cycle after the grant.
- `ram_we`  out  1  VRAM write enable.
- `ram_addr`  out  AW  VRAM address.
- `ram_din`  out  DW  VRAM write data.
- `ram_dout`  in  DW  VRAM read data; registered RAM, valid the cycle after the address.
- `ovf_clr`  in  1  clears the sticky overflow flag.
- `wbuf_full`  out  1  FIFO holds `DEPTH` entries.
- `wbuf_empty`  out  1  FIFO holds 0 entries.
- `wbuf_level`  out  log2(DEPTH)+1  current entry count.
- `wbuf_ovf`  out  1  sticky: a CPU write was dropped.

## Operation

- **FIFO storage:** `DEPTH` entries of {word address, data}. Registered read/write pointers of log2(DEPTH) bits wrap modulo `DEPTH`. A separate registered count runs 0..`DEPTH`.
- **Push:** `cpu_we & ~wbuf_full`, where full is evaluated on the current registered count.
- **Drop on full:** a push while full is discarded and sets `wbuf_ovf`. This holds even if a pop occurs in the same cycle. There is no bypass of a full FIFO.
- **Pop (drain):** `~vga_req & ~wbuf_empty`.
- **Arbitration:** fixed priority, one RAM operation per cycle, combinational from registered state and current requests.
  - `vga_req` = 1: `ram_addr` = `vga_addr`, `ram_we` = 0. The FIFO holds.
  - `vga_req` = 0 and FIFO non-empty: `ram_addr` = head address, `ram_din` = head data, `ram_we` = 1. The head pops at the clock edge.
  - Otherwise: `ram_we` = 0; `ram_addr` = `vga_addr` (don't-care).
- **Simultaneous push and pop (not full):** count unchanged, both pointers advance.
- **Empty bypass:** a push into an empty FIFO cannot reach RAM in the same cycle. The write appears at the earliest one cycle later.
- **Ordering:** writes reach VRAM in CPU issue order. Repeated writes to one address are all performed, and the last one wins.
- **Read-after-write coherence:** a scanout read of an address with a pending FIFO write returns the old RAM contents. This is accepted behaviour; no forwarding.
- **`wbuf_ovf`:** set by a dropped push; cleared by `ovf_clr` or `clr`. A set and a clear in the same cycle leave it set.
- **`vga_valid`:** registered copy of `vga_req`. `vga_data` = `ram_dout` passed through.

## Timing

- **Reset (`clr` high at an edge):** pointers = 0, count = 0, `wbuf_empty` = 1, `wbuf_full` = 0, `wbuf_level` = 0, `wbuf_ovf` = 0, `vga_valid` = 0. Because `ram_we` is derived from empty, it is 0 in the cycle after reset.
- **Reset mid-operation:** all queued writes are discarded with no further `ram_we`. A `vga_valid` that was due is suppressed.
- **Write latency:** a CPU store in cycle N is queued at edge N. With no scanout and an empty FIFO, `ram_we` is asserted in cycle N+1.
- **Scanout read latency:** `vga_req` in cycle N gives `vga_valid` = 1 and data in cycle N+1.
- **Starvation:** a queued write waits indefinitely while `vga_req` stays high. Software must poll `wbuf_full` before bursts.
- **Flag updates:** status flags update at the edge following the push/pop and are registered (no combinational path from `cpu_we`).

## Test plan

1. **Reset, then single write:** `cpu_we` with addr 0xC0000010 and data 0xDEADBEEF in cycle 1. Expect cycle 2: `ram_we` = 1, `ram_addr` = 4, `ram_din` = 0xDEADBEEF. Expect cycle 3: `wbuf_empty` = 1.
2. **Scanout priority:** `vga_req` held high for 10 cycles, with 3 CPU writes during that window. Expect `ram_we` = 0 throughout, `vga_valid` high in cycles 2..11, and `wbuf_level` = 3. After release, 3 consecutive `ram_we` cycles occur in issue order.
3. **Overflow:** `vga_req` high, then 5 writes with `DEPTH` = 4. Expect `wbuf_full` = 1, `wbuf_ovf` = 1, and only the first 4 writes drained. Pulsing `ovf_clr` returns `wbuf_ovf` to 0.
4. **Full with simultaneous pop:** FIFO full, `vga_req` drops, and `cpu_we` is high in the same cycle. Expect the push dropped, `wbuf_ovf` = 1, and `wbuf_level` going 4 → 3.
5. **Wrap-around:** 10 interleaved write/drain cycles with `DEPTH` = 4. Expect addresses and data to reach RAM in order across pointer wrap, and `wbuf_level` never exceeding 4.
6. **Reset mid-drain:** 3 entries queued, `clr` asserted for 1 cycle. Expect no `ram_we` afterwards, `wbuf_empty` = 1, and `wbuf_ovf` = 0.

Source files
------------

// File: rtl/vram_wr_arbiter.sv
// rtl/vram_wr_arbiter.sv - VRAM port arbiter: posted CPU write FIFO drained around VGA scanout reads
//
// Ports:
//   clk, clr                 system clock, synchronous active-high reset
//   cpu_we/addr/data         CPU store into VRAM space; never stalled
//   vga_req/addr             scanout read request; always wins the RAM port
//   vga_data, vga_valid      scanout read data, valid one cycle after the request
//   ram_we/addr/din/dout     single-port synchronous VRAM
//   ovf_clr                  clears the sticky overflow flag
//   wbuf_full/empty/level    write FIFO status, derived from the registered count
//   wbuf_ovf                 sticky: a CPU write was dropped because the FIFO was full

module vram_wr_arbiter #(
    parameter int AW    = 13,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     cpu_we,
    input  logic [31:0]              cpu_addr,
    input  logic [DW-1:0]            cpu_data,
    input  logic                     vga_req,
    input  logic [AW-1:0]            vga_addr,
    output logic [DW-1:0]            vga_data,
    output logic                     vga_valid,
    output logic                     ram_we,
    output logic [AW-1:0]            ram_addr,
    output logic [DW-1:0]            ram_din,
    input  logic [DW-1:0]            ram_dout,
    input  logic                     ovf_clr,
    output logic                     wbuf_full,
    output logic                     wbuf_empty,
    output logic [$clog2(DEPTH):0]   wbuf_level,
    output logic                     wbuf_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          ovf_q;
    logic          valid_q;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Byte address bits outside the VRAM word index are not decoded here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

    // Status comes straight from the registered count, so there is no
    // combinational path from cpu_we to any flag.
    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);

    // Full is judged on the registered count only: a pop in the same cycle
    // does not make room for the push.
    assign push = cpu_we & ~full;
    assign pop  = ~vga_req & ~empty;

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as ovf_clr wins so no overflow is lost.
            if (cpu_we && full) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            valid_q <= vga_req;
        end
    end

    // Entry storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= cpu_addr[AW+1:2];
            data_mem[wr_ptr] <= cpu_data;
        end
    end

    // Fixed priority: scanout read, then FIFO head write, else idle.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = vga_addr;
        ram_din  = data_mem[rd_ptr];
        if (!vga_req && !empty) begin
            ram_we   = 1'b1;
            ram_addr = addr_mem[rd_ptr];
        end
    end

    assign vga_data   = ram_dout;
    assign vga_valid  = valid_q;
    assign wbuf_full  = full;
    assign wbuf_empty = empty;
    assign wbuf_level = count;
    assign wbuf_ovf   = ovf_q;

endmodule
